// File: rtl/ifid_pipe_pkg.sv
// Shared definitions for the IF/ID pipeline register: widths, opcodes, NOP word
// and the per-edge update selector.
package ifid_pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 6;

    localparam logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [OP_W-1:0] {
        OpRtype = 6'd0,
        OpBeq   = 6'd4,
        OpBne   = 6'd5,
        OpLw    = 6'd35,
        OpSw    = 6'd43
    } opcode_e;

    typedef enum logic [1:0] {
        UpdLoad,
        UpdStall,
        UpdFlush
    } upd_e;

endpackage

// File: rtl/ifid_pipe_if.sv
// IF/ID pipeline bus: IF-stage and EX-stage inputs plus decode-side outputs.
interface ifid_pipe_if
    import ifid_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) ();

    logic [DATA_W-1:0] instruction;
    logic [DATA_W-1:0] output_pc;
    logic              mux_ctrl;
    logic              ex_mem_read;
    logic [REG_W-1:0]  ex_rt;

    logic [DATA_W-1:0] id_instruction;
    logic [DATA_W-1:0] id_pc;
    logic              id_valid;
    logic              lw_hazard;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output instruction, output_pc, mux_ctrl, ex_mem_read, ex_rt,
        input  id_instruction, id_pc, id_valid, lw_hazard, stall_cnt, flush_cnt
    );

    modport slave (
        input  instruction, output_pc, mux_ctrl, ex_mem_read, ex_rt,
        output id_instruction, id_pc, id_valid, lw_hazard, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/ifid_pipe_hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
// Purely combinational; only the opcode/rs/rt half of the word is needed.
module hazard_detect
    import ifid_pipe_pkg::*;
(
    input  logic [15:0]      i_instr_hi,
    input  logic             i_valid,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rt,
    output logic             o_lw_hazard
);

    logic [OP_W-1:0]  w_op;
    logic [REG_W-1:0] w_rs;
    logic [REG_W-1:0] w_rt;
    logic             w_uses_rt;

    assign w_op = i_instr_hi[15:10];
    assign w_rs = i_instr_hi[9:5];
    assign w_rt = i_instr_hi[4:0];

    // Only these formats read rt as a source; I-type ALU ops write it.
    always_comb begin
        w_uses_rt = 1'b0;
        case (w_op)
            OpRtype, OpBeq, OpBne, OpSw: w_uses_rt = 1'b1;
            default:                     w_uses_rt = 1'b0;
        endcase
    end

    assign o_lw_hazard = i_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                         ((i_ex_rt == w_rs) || (w_uses_rt && (i_ex_rt == w_rt)));

endmodule

// File: rtl/ifid_pipe.sv
// IF/ID pipeline register with branch flush, load-use stall and saturating
// stall/flush event counters.
module ifid_pipe
    import ifid_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    ifid_pipe_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_id_instruction;
    logic [DATA_W-1:0] r_id_pc;
    logic              r_id_valid;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_lw_hazard;
    upd_e              w_upd;

    hazard_detect u_hazard_detect (
        .i_instr_hi    (r_id_instruction[31:16]),
        .i_valid       (r_id_valid),
        .i_ex_mem_read (bus.ex_mem_read),
        .i_ex_rt       (bus.ex_rt),
        .o_lw_hazard   (w_lw_hazard)
    );

    // Branch flush wins over a pending stall.
    always_comb begin
        w_upd = UpdLoad;
        if (bus.mux_ctrl) begin
            w_upd = UpdFlush;
        end else if (w_lw_hazard) begin
            w_upd = UpdStall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_instruction <= NOP_WORD;
            r_id_pc          <= '0;
            r_id_valid       <= 1'b0;
            r_stall_cnt      <= '0;
            r_flush_cnt      <= '0;
        end else begin
            case (w_upd)
                UpdFlush: begin
                    r_id_instruction <= NOP_WORD;
                    r_id_pc          <= '0;
                    r_id_valid       <= 1'b0;
                    if (r_flush_cnt != CNT_MAX) begin
                        r_flush_cnt <= r_flush_cnt + CNT_ONE;
                    end
                end
                UpdStall: begin
                    if (r_stall_cnt != CNT_MAX) begin
                        r_stall_cnt <= r_stall_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_id_instruction <= bus.instruction;
                    r_id_pc          <= bus.output_pc;
                    r_id_valid       <= 1'b1;
                end
            endcase
        end
    end

    assign bus.id_instruction = r_id_instruction;
    assign bus.id_pc          = r_id_pc;
    assign bus.id_valid       = r_id_valid;
    assign bus.lw_hazard      = w_lw_hazard;
    assign bus.stall_cnt      = r_stall_cnt;
    assign bus.flush_cnt      = r_flush_cnt;

endmodule

// File: doc/ifid_pipe.md
IFID_PIPE -- requirements
Module: ifid_pipe

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall and flush event counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 instruction  input  32  fetched word from IF stage.
REQ-005 output_pc  input  32  PC+1 (word-addressed) from IF stage.
REQ-006 mux_ctrl  input  1  branch taken, same signal driving IF next-PC select; flushes IF/ID.
REQ-007 ex_mem_read  input  1  instruction in EX is a load (lw).
REQ-008 ex_rt  input  5  destination register of the instruction in EX.
REQ-009 id_instruction  output  32  registered instruction presented to decode.
REQ-010 id_pc  output  32  registered PC+1 presented to decode.
REQ-011 id_valid  output  1  id_instruction holds a real, non-flushed instruction.
REQ-012 lw_hazard  output  1  load-use stall request to IF (hold PC) and to ID/EX (insert bubble).
REQ-013 stall_cnt  output  CNT_W  count of stalled cycles.
REQ-014 flush_cnt  output  CNT_W  count of flush events.

Function
REQ-015 Field decode from id_instruction: opcode [31:26], rs [25:21], rt [20:16].
REQ-016 uses_rt true for opcode 0 (R-type), 4 (beq), 5 (bne), 43 (sw); false otherwise.
REQ-017 lw_hazard combinational = id_valid AND ex_mem_read AND ex_rt!=0 AND (ex_rt==rs OR (uses_rt AND ex_rt==rt)).
REQ-018 Update priority at each rising edge: flush > stall > load.
REQ-019 Flush (mux_ctrl=1): id_instruction<=0 (nop), id_pc<=0, id_valid<=0, regardless of lw_hazard.
REQ-020 Stall (mux_ctrl=0, lw_hazard=1): id_instruction, id_pc, id_valid hold their values.
REQ-021 Load (mux_ctrl=0, lw_hazard=0): id_instruction<=instruction, id_pc<=output_pc, id_valid<=1.
REQ-022 Latency: IF word visible on id_instruction one rising edge after capture; no combinational path from instruction to any output.
REQ-023 Stall duration: a single lw in EX produces exactly one stall cycle; lw_hazard deasserts when ex_mem_read drops next cycle (ID/EX bubble).
REQ-024 ex_rt=0 never raises lw_hazard (register $zero).
REQ-025 id_valid=0 never raises lw_hazard (flushed slot cannot stall).
REQ-026 stall_cnt increments by 1 on each edge where the stall branch of REQ-020 is taken; saturates at all-ones, no wrap.
REQ-027 flush_cnt increments by 1 on each edge where mux_ctrl=1; saturates at all-ones, no wrap.
REQ-028 Simultaneous mux_ctrl=1 and lw_hazard=1: flush taken, flush_cnt increments, stall_cnt does not.

Reset
REQ-029 rst_n low asynchronously forces id_instruction=0, id_pc=0, id_valid=0, stall_cnt=0, flush_cnt=0; lw_hazard therefore 0.
REQ-030 Reset asserted mid-stall or mid-flush overrides all; first rising edge after rst_n release performs a normal load.

Structure
REQ-031 Shared package holds: opcode constants (R-type, beq, bne, sw, lw), NOP word (32'h0), data width 32, register index width 5.
REQ-032 One combinational sub-module, hazard_detect, implements REQ-016/017; ifid_pipe instantiates it and owns all registers and counters.

Verification
REQ-033 Reset: rst_n=0 mid-run with nonzero state -> all outputs 0 immediately, before next clk edge.
REQ-034 Load-use: ID holds add $3,$1,$2 (0x00221820), EX lw with ex_rt=1 -> lw_hazard=1, ID holds 0x00221820 one cycle, stall_cnt=1; next cycle ex_mem_read=0 -> new instruction loaded.
REQ-035 rt-only check: ID holds addi $5,$2,4 (0x20450004), ex_rt=5, ex_mem_read=1 -> lw_hazard=0; ID holds sw $5,0($2) (0xAC450000), ex_rt=5 -> lw_hazard=1.
REQ-036 Flush priority: lw_hazard=1 and mux_ctrl=1 same edge -> id_instruction=0, id_valid=0, flush_cnt+1, stall_cnt unchanged; lw_hazard=0 next cycle.
REQ-037 Zero register: ex_mem_read=1, ex_rt=0, ID rs=0 -> lw_hazard=0.
REQ-038 Saturation: CNT_W=4, hold stall condition 20 cycles -> stall_cnt reaches 15 and stays 15.
